// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready word intake, frames it as start, LSB-first data,
// optional parity and 1-2 stop bits, and drives registered, glitch-free tx_out.
module uart_tx_serializer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
  localparam int                IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DATA_BITS - 1);
  localparam bit                HAS_PAR   = (PARITY == 1) || (PARITY == 2);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   tx_out_q, tx_out_d;
  logic                   busy_q, busy_d;
  logic                   ready_q, ready_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  // Odd parity is the inverted XOR so an all-zero word still carries a 1.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    parity_of = (PARITY == 1) ? ~^w : ^w;
  endfunction

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid && ready_q) begin
          shreg_d = tx_data;
          par_d   = parity_of(tx_data);
          cnt_d   = '0;
          idx_d   = '0;
          stop_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_MAX) begin
            idx_d   = '0;
            stop_d  = 1'b0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) state_d = S_IDLE;
          else                     stop_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from next-state values so the registered pins line up with the state.
    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shreg_d[0];
      S_PARITY: tx_out_d = par_d;
      default:  tx_out_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_STOP) && (stop_d == STOP_LAST) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign busy     = busy_q;
  assign tx_ready = ready_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four parameterisations share one clock; expected line bits
// are queued as each word is presented and popped as the serial frame appears.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] vld;
  logic [7:0] din [4];
  logic [3:0] txo, bsy, rdy, dn;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic exp_q[$];
  int nbits [4] = '{10, 10, 10, 11};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1)) u_basic (
    .clk(clk), .reset(rst_n), .tx_data(din[0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx_out(txo[0]), .busy(bsy[0]), .tx_done(dn[0]));
  uart_tx_serializer #(.DATA_BITS(7), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(rst_n), .tx_data(din[1][6:0]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx_out(txo[1]), .busy(bsy[1]), .tx_done(dn[1]));
  uart_tx_serializer #(.DATA_BITS(7), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(rst_n), .tx_data(din[2][6:0]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx_out(txo[2]), .busy(bsy[2]), .tx_done(dn[2]));
  uart_tx_serializer #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .reset(rst_n), .tx_data(din[3]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx_out(txo[3]), .busy(bsy[3]), .tx_done(dn[3]));

  // Expected line bits for one frame: start, data LSB first, parity, stop bits.
  task automatic push_frame(input int d, input logic [7:0] w);
    int db;
    logic [6:0] w7;
    db = (d == 1 || d == 2) ? 7 : 8;
    w7 = w[6:0];
    exp_q.push_back(1'b0);
    for (int i = 0; i < db; i++) exp_q.push_back(w[i]);
    if (d == 1) exp_q.push_back(^w7);
    if (d == 2) exp_q.push_back(~^w7);
    exp_q.push_back(1'b1);
    if (d == 3) exp_q.push_back(1'b1);
  endtask

  task automatic wait_ready(input int d);
    int waited = 0;
    while (rdy[d] !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (rdy[d] !== 1'b1) begin
      $display("FAIL wait_ready dut%0d: tx_ready=%b, required 1 within 200 cycles", d, rdy[d]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
    end
  endtask

  task automatic send(input int d, input logic [7:0] w);
    wait_ready(d);
    vld[d] = 1'b1;
    din[d] = w;
    push_frame(d, w);
    @(negedge clk);
    vld[d] = 1'b0;
  endtask

  task automatic rx_frame(input int d, input string nm, output int fall_cyc);
    int   nb;
    int   waited = 0;
    logic e, got;
    bit   ok, done_ok, busy_ok;
    nb = nbits[d];
    fall_cyc = 0;
    while (txo[d] !== 1'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (txo[d] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s start: tx_out=%b, required 0 within 200 cycles", nm, txo[d]);
      for (int i = 0; i < nb && exp_q.size() > 0; i++) void'(exp_q.pop_front());
      return;
    end
    fall_cyc = cyc;
    done_ok = 1'b1;
    busy_ok = 1'b1;
    for (int b = 0; b < nb; b++) begin
      e   = exp_q.pop_front();
      ok  = 1'b1;
      got = e;
      for (int c = 0; c < C; c++) begin
        if (txo[d] !== e) begin ok = 1'b0; got = txo[d]; end
        if (bsy[d] !== 1'b1) busy_ok = 1'b0;
        if (dn[d] !== ((b == nb - 1 && c == C - 1) ? 1'b1 : 1'b0)) done_ok = 1'b0;
        @(negedge clk);
      end
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s bit%0d: tx_out=%b in its period, required %b for %0d cycles", nm, b, got, e, C);
      end
    end
    n_cmp++;
    if (!done_ok) begin
      n_bad++;
      $display("FAIL %s tx_done: pulse misplaced, required 1 only in cycle %0d of frame", nm, nb * C);
    end
    n_cmp++;
    if (!busy_ok) begin
      n_bad++;
      $display("FAIL %s busy: dropped during frame, required 1 for %0d cycles", nm, nb * C);
    end
    n_cmp++;
    if ({txo[d], bsy[d], rdy[d], dn[d]} !== 4'b1010) begin
      n_bad++;
      $display("FAIL %s idle_after: {tx_out,busy,ready,done}=%b, required 1010", nm,
               {txo[d], bsy[d], rdy[d], dn[d]});
    end
  endtask

  task automatic test_reset();
    bit ok = 1'b1;
    rst_n = 1'b0;
    vld   = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({txo, bsy, rdy, dn} !== 16'hF000) begin
      n_bad++;
      $display("FAIL reset_state: {tx_out,busy,ready,done}=%h, required f000", {txo, bsy, rdy, dn});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rdy !== 4'hF) begin
      n_bad++;
      $display("FAIL ready_after_release: tx_ready=%b, required 1111", rdy);
    end
    for (int i = 0; i < 20; i++) begin
      if (txo !== 4'hF || bsy !== 4'h0 || dn !== 4'h0 || rdy !== 4'hF) ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL idle_hold: outputs left idle levels, required tx_out=1 busy=0 done=0 ready=1");
    end
  endtask

  task automatic test_basic_frame();
    int f;
    send(0, 8'hA5);
    rx_frame(0, "basic_A5", f);
  endtask

  task automatic test_parity();
    int f;
    send(1, 8'h53);
    rx_frame(1, "even_53", f);
    send(2, 8'h53);
    rx_frame(2, "odd_53", f);
    send(1, 8'h00);
    rx_frame(1, "even_00", f);
    send(2, 8'h00);
    rx_frame(2, "odd_00", f);
  endtask

  task automatic test_back_to_back();
    int f0, f1;
    wait_ready(3);
    vld[3] = 1'b1;
    din[3] = 8'h00;
    push_frame(3, 8'h00);
    push_frame(3, 8'hFF);
    @(negedge clk);
    din[3] = 8'hFF;
    rx_frame(3, "b2b_00", f0);
    @(negedge clk);
    vld[3] = 1'b0;
    rx_frame(3, "b2b_FF", f1);
    n_cmp++;
    if (f1 - f0 != 11 * C + 1) begin
      n_bad++;
      $display("FAIL b2b_spacing: start-to-start=%0d cycles, required %0d", f1 - f0, 11 * C + 1);
    end
  endtask

  task automatic test_reset_midframe();
    int f;
    bit ok = 1'b1;
    wait_ready(0);
    vld[0] = 1'b1;
    din[0] = 8'h3C;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (17) @(negedge clk);
    n_cmp++;
    if ({txo[0], bsy[0]} !== 2'b11) begin
      n_bad++;
      $display("FAIL pre_reset_bit3: {tx_out,busy}=%b, required 11", {txo[0], bsy[0]});
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({txo[0], bsy[0], rdy[0], dn[0]} !== 4'b1000) begin
      n_bad++;
      $display("FAIL async_reset: {tx_out,busy,ready,done}=%b, required 1000", {txo[0], bsy[0], rdy[0], dn[0]});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txo[0] !== 1'b1 || bsy[0] !== 1'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL residual_bits: line active after reset, required tx_out=1 busy=0");
    end
    send(0, 8'hC3);
    rx_frame(0, "after_reset_C3", f);
  endtask

  task automatic test_ignored_valid();
    int f;
    bit ok = 1'b1;
    send(0, 8'h22);
    fork
      rx_frame(0, "busy_22", f);
      begin
        repeat (12) @(negedge clk);
        vld[0] = 1'b1;
        din[0] = 8'h11;
        repeat (2) @(negedge clk);
        vld[0] = 1'b0;
        din[0] = 8'h00;
      end
    join
    for (int i = 0; i < 40; i++) begin
      if (txo[0] !== 1'b1 || bsy[0] !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL ignored_11: extra frame on line, required tx_out=1 busy=0");
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    test_ignored_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
